mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 40 ++++
 rtl/mem_align.sv | 53 +++++
 rtl/mem_stage.sv | 108 ++++++++++
 tb/tb_mem_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the RV32I memory-access stage.
//   - RV32I opcodes used by the stage (load / store)
//   - load_funct3_t / store_funct3_t : legal access encodings
//   - mem_state_t                    : memory-stage control FSM states
//   - is_legal_load / is_legal_store : funct3 legality helpers
package mem_stage_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } mem_state_t;

  function automatic logic is_legal_load(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic is_legal_store(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane alignment for data-memory accesses.
// Ports:
//   funct3   in  3   access size (bits [1:0]: 00 byte, 01 half, 10 word)
//   addr_lo  in  2   alu_out[1:0]
//   rs2_out  in  32  store source data
//   mask     out 4   byte-lane mask
//   wdata    out 32  store data shifted onto its lanes
//   misalign out 1   misaligned half/word access
// Build option: MEM_MISALIGN_CHECK_EN enables misalign detection; otherwise
// misalign is 0 and the unused low address bits are ignored.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2_out,
  output logic [3:0]  mask,
  output logic [31:0] wdata,
  output logic        misalign
);

  always_comb begin
    mask  = 4'b1111;
    wdata = rs2_out;
    case (funct3[1:0])
      2'b00: begin
        mask  = 4'b0001 << addr_lo;
        wdata = rs2_out << {addr_lo, 3'b000};
      end
      2'b01: begin
        mask  = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = rs2_out << {addr_lo[1], 4'b0000};
      end
      default: begin
        mask  = 4'b1111;
        wdata = rs2_out;
      end
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    case (funct3[1:0])
      2'b01:   misalign = addr_lo[0];
      2'b10:   misalign = (addr_lo != 2'b00);
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage RV32I pipeline (EX/MEM -> MEM/WB).
// Issues one data-memory request per load/store, aligns store data and byte
// enables, stalls until the memory responds and captures the raw read word.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid, opcode, funct3, alu_out, rs2_out : from EX/MEM
//   advance                                    : MEM/WB loads this cycle
//   dmem_*                                     : data-memory interface
//   mem_rdata, mem_byte_enable                 : to MEM/WB
//   mem_stall                                  : freeze request to hazard unit
//   misalign                                   : misaligned access flag
// Build option: MEM_MISALIGN_CHECK_EN (see mem_align).
//
// state | meaning
// IDLE  | no access outstanding; a new access issues combinationally
// BUSY  | request outstanding, waiting for dmem_resp
// HOLD  | response captured, waiting for advance; no request
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_out,
  input  logic [31:0] rs2_out,
  input  logic        advance,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_rdata,
  output logic [3:0]  mem_byte_enable,
  output logic        mem_stall,
  output logic        misalign
);

  mem_state_t  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  logic [3:0]  mask;
  logic        mis_raw;
  logic        is_load, is_store, is_ls, mem_op, req, accept;

  mem_align u_align (
    .funct3   (funct3),
    .addr_lo  (alu_out[1:0]),
    .rs2_out  (rs2_out),
    .mask     (mask),
    .wdata    (dmem_wdata),
    .misalign (mis_raw)
  );

  assign is_load  = in_valid && (opcode == OP_LOAD)  && is_legal_load(funct3);
  assign is_store = in_valid && (opcode == OP_STORE) && is_legal_store(funct3);
  assign is_ls    = is_load || is_store;
  assign mem_op   = is_ls && !mis_raw;

  // Request is live until the response arrives; HOLD never re-issues.
  assign req    = mem_op && (state_q != HOLD) && !rst;
  assign accept = req && dmem_resp;

  assign dmem_read        = req && is_load;
  assign dmem_write       = req && is_store;
  assign dmem_address     = {alu_out[31:2], 2'b00};
  assign dmem_byte_enable = req ? mask : 4'b0000;
  assign mem_byte_enable  = is_ls ? mask : 4'b0000;
  assign mem_stall        = req && !dmem_resp;
  assign misalign         = is_ls && mis_raw && !rst;
  // Stray responses (no request outstanding) never reach MEM/WB.
  assign mem_rdata        = accept ? dmem_rdata : rdata_q;

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE, BUSY: begin
        if (!mem_op) begin
          state_d = IDLE;
        end else if (dmem_resp) begin
          rdata_d = dmem_rdata;
          state_d = advance ? IDLE : HOLD;
        end else begin
          state_d = BUSY;
        end
      end
      HOLD: begin
        if (advance) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stores, loads with HOLD, bubbles,
// reset mid-access and misaligned access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] alu_out;
  logic [31:0] rs2_out;
  logic        advance;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic [31:0] mem_rdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_stall;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] ALU = 7'b0110011;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .opcode           (opcode),
    .funct3           (funct3),
    .alu_out          (alu_out),
    .rs2_out          (rs2_out),
    .advance          (advance),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_resp        (dmem_resp),
    .dmem_rdata       (dmem_rdata),
    .mem_rdata        (mem_rdata),
    .mem_byte_enable  (mem_byte_enable),
    .mem_stall        (mem_stall),
    .misalign         (misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    in_valid = v;
    opcode   = op;
    funct3   = f3;
    alu_out  = a;
    rs2_out  = d;
  endtask

  initial begin
    rst = 1'b1; advance = 1'b0; dmem_resp = 1'b0; dmem_rdata = 32'h0;
    drive(1'b0, 7'h0, 3'h0, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_read",   {31'h0, dmem_read},  32'h0);
    chk("rst_write",  {31'h0, dmem_write}, 32'h0);
    chk("rst_stall",  {31'h0, mem_stall},  32'h0);
    chk("rst_mis",    {31'h0, misalign},   32'h0);
    chk("rst_rdata",  mem_rdata,           32'h0);
    rst = 1'b0;
    tick();

    // SW 0x100, response on the 4th cycle
    drive(1'b1, ST, 3'b010, 32'h100, 32'hDEADBEEF);
    #1;
    chk("sw_c1_write", {31'h0, dmem_write}, 32'h1);
    chk("sw_c1_be",    {28'h0, dmem_byte_enable}, 32'hF);
    chk("sw_c1_addr",  dmem_address, 32'h100);
    chk("sw_c1_wdata", dmem_wdata, 32'hDEADBEEF);
    chk("sw_c1_stall", {31'h0, mem_stall}, 32'h1);
    tick();
    chk("sw_c2_write", {31'h0, dmem_write}, 32'h1);
    chk("sw_c2_stall", {31'h0, mem_stall}, 32'h1);
    tick();
    chk("sw_c3_addr",  dmem_address, 32'h100);
    chk("sw_c3_stall", {31'h0, mem_stall}, 32'h1);
    tick();
    dmem_resp = 1'b1; advance = 1'b1;
    #1;
    chk("sw_resp_stall", {31'h0, mem_stall}, 32'h0);
    tick();
    dmem_resp = 1'b0; advance = 1'b0;
    drive(1'b0, ST, 3'b010, 32'h100, 32'hDEADBEEF);
    #1;
    chk("sw_after_write", {31'h0, dmem_write}, 32'h0);

    // SB 0x103, immediate response
    drive(1'b1, ST, 3'b000, 32'h103, 32'h000000AB);
    dmem_resp = 1'b1; advance = 1'b1;
    #1;
    chk("sb_write", {31'h0, dmem_write}, 32'h1);
    chk("sb_be",    {28'h0, dmem_byte_enable}, 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hAB000000);
    chk("sb_stall", {31'h0, mem_stall}, 32'h0);
    tick();

    // SH 0x102, immediate response
    drive(1'b1, ST, 3'b001, 32'h102, 32'h0000BEEF);
    #1;
    chk("sh_be",    {28'h0, dmem_byte_enable}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hBEEF0000);
    chk("sh_addr",  dmem_address, 32'h100);
    tick();
    dmem_resp = 1'b0; advance = 1'b0;

    // LW 0x200, response on 3rd cycle, advance late by 2 cycles
    drive(1'b1, LD, 3'b010, 32'h200, 32'h0);
    #1;
    chk("lw_c1_read",  {31'h0, dmem_read}, 32'h1);
    chk("lw_c1_stall", {31'h0, mem_stall}, 32'h1);
    chk("lw_c1_be",    {28'h0, dmem_byte_enable}, 32'hF);
    tick();
    chk("lw_c2_read",  {31'h0, dmem_read}, 32'h1);
    tick();
    dmem_resp = 1'b1; dmem_rdata = 32'h12345678;
    #1;
    chk("lw_resp_rdata", mem_rdata, 32'h12345678);
    chk("lw_resp_stall", {31'h0, mem_stall}, 32'h0);
    tick();
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
    #1;
    chk("lw_hold1_read",  {31'h0, dmem_read}, 32'h0);
    chk("lw_hold1_stall", {31'h0, mem_stall}, 32'h0);
    chk("lw_hold1_rdata", mem_rdata, 32'h12345678);
    chk("lw_hold1_mbe",   {28'h0, mem_byte_enable}, 32'hF);
    tick();
    chk("lw_hold2_read",  {31'h0, dmem_read}, 32'h0);
    chk("lw_hold2_rdata", mem_rdata, 32'h12345678);
    advance = 1'b1;
    tick();
    advance = 1'b0;
    // New load at the next address: must issue from IDLE
    drive(1'b1, LD, 3'b100, 32'h205, 32'h0);
    #1;
    chk("lbu_issue_read", {31'h0, dmem_read}, 32'h1);
    chk("lbu_issue_be",   {28'h0, dmem_byte_enable}, 32'h2);
    dmem_resp = 1'b1; dmem_rdata = 32'h0000AA00; advance = 1'b1;
    tick();
    dmem_resp = 1'b0; advance = 1'b0;

    // Bubble, ALU op, illegal load funct3
    drive(1'b0, LD, 3'b010, 32'h300, 32'h0);
    #1;
    chk("bubble_read",  {31'h0, dmem_read}, 32'h0);
    chk("bubble_stall", {31'h0, mem_stall}, 32'h0);
    drive(1'b1, ALU, 3'b000, 32'h300, 32'h0);
    #1;
    chk("add_req",   {30'h0, dmem_read, dmem_write}, 32'h0);
    chk("add_stall", {31'h0, mem_stall}, 32'h0);
    drive(1'b1, LD, 3'b011, 32'h300, 32'h0);
    #1;
    chk("ill_req",   {30'h0, dmem_read, dmem_write}, 32'h0);
    chk("ill_stall", {31'h0, mem_stall}, 32'h0);
    chk("ill_rdata", mem_rdata, 32'h0000AA00);
    tick();

    // Reset while BUSY on a load
    drive(1'b1, LD, 3'b010, 32'h300, 32'h0);
    tick();
    chk("rb_busy_read", {31'h0, dmem_read}, 32'h1);
    rst = 1'b1;
    tick();
    chk("rb_read",  {31'h0, dmem_read}, 32'h0);
    chk("rb_stall", {31'h0, mem_stall}, 32'h0);
    chk("rb_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    drive(1'b0, LD, 3'b010, 32'h300, 32'h0);
    #1;
    chk("rb_post_read",  {31'h0, dmem_read}, 32'h0);
    chk("rb_post_rdata", mem_rdata, 32'h0);
    tick();

    // LW at 0x202
    drive(1'b1, LD, 3'b010, 32'h202, 32'h0);
    #1;
`ifdef MEM_MISALIGN_CHECK_EN
    chk("mis_flag",  {31'h0, misalign}, 32'h1);
    chk("mis_read",  {31'h0, dmem_read}, 32'h0);
    chk("mis_stall", {31'h0, mem_stall}, 32'h0);
    chk("mis_rdata", mem_rdata, 32'h0);
    tick();
`else
    chk("mis_flag", {31'h0, misalign}, 32'h0);
    chk("mis_read", {31'h0, dmem_read}, 32'h1);
    chk("mis_addr", dmem_address, 32'h200);
    chk("mis_be",   {28'h0, dmem_byte_enable}, 32'hF);
    dmem_resp = 1'b1; dmem_rdata = 32'hCAFEF00D; advance = 1'b1;
    #1;
    chk("mis_rdata", mem_rdata, 32'hCAFEF00D);
    tick();
    dmem_resp = 1'b0; advance = 1'b0;
`endif
    drive(1'b0, 7'h0, 3'h0, 32'h0, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
